regbank_ctrl: RTL and testbench

REGBANK_CTRL -- requirements
Module: regbank_ctrl

---
 rtl/regbank_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_regbank_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_ctrl.sv
// Register-bank write/read controller: logical-to-physical index mapping by CPU
// mode, two arbitrated write ports, and a three-step exception entry sequencer.
module regbank_ctrl #(
   parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rd1_lidx,
   input  logic [4:0]  rd2_lidx,
   output logic [4:0]  bank_ridx1,
   output logic [4:0]  bank_ridx2,
   input  logic        alu_wvalid,
   input  logic [4:0]  alu_widx,
   input  logic [31:0] alu_wdata,
   output logic        alu_wready,
   input  logic        ld_wvalid,
   input  logic [4:0]  ld_widx,
   input  logic [31:0] ld_wdata,
   output logic        ld_wready,
   input  logic        exc_req,
   input  logic [1:0]  exc_type,
   input  logic [31:0] exc_ret_addr,
   output logic        exc_busy,
   output logic        exc_done,
   output logic        bank_we,
   output logic [4:0]  bank_widx,
   output logic [31:0] bank_wdata,
   output logic [4:0]  mode
);

   localparam logic [4:0] MODE_SVC = 5'h13;
   localparam logic [4:0] MODE_ABT = 5'h17;
   localparam logic [4:0] MODE_IRQ = 5'h12;
   localparam logic [4:0] MODE_UND = 5'h1B;
   localparam logic [4:0] IDX_CPSR = 5'd16;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SPSR,
      ST_LR,
      ST_CPSR,
      ST_DONE
   } state_t;

   // First physical index of the banked r13/r14/SPSR triple; 0 = mode has no bank.
   function automatic logic [4:0] f_mode_base(input logic [4:0] md);
      case (md)
         MODE_SVC: f_mode_base = 5'd17;
         MODE_ABT: f_mode_base = 5'd20;
         MODE_IRQ: f_mode_base = 5'd23;
         MODE_UND: f_mode_base = 5'd26;
         default:  f_mode_base = 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] f_rmap(input logic [4:0] lidx, input logic [4:0] md);
      logic [4:0] base;
      base = f_mode_base(md);
      if (lidx <= 5'd12 || lidx == 5'd15 || lidx == IDX_CPSR) begin
         f_rmap = lidx;
      end else if (lidx == 5'd13 || lidx == 5'd14) begin
         f_rmap = (base != 5'd0) ? base + {4'd0, ~lidx[0]} : lidx;
      end else if (lidx == 5'd17) begin
         f_rmap = (base != 5'd0) ? base + 5'd2 : IDX_CPSR;
      end else begin
         f_rmap = 5'd0;
      end
   endfunction

   function automatic logic f_wkeep(input logic [4:0] lidx, input logic [4:0] md);
      f_wkeep = (lidx <= 5'd16) || (lidx == 5'd17 && f_mode_base(md) != 5'd0);
   endfunction

   function automatic logic [4:0] f_exc_base(input logic [1:0] t);
      case (t)
         2'd0:    f_exc_base = 5'd17;
         2'd1:    f_exc_base = 5'd20;
         2'd2:    f_exc_base = 5'd23;
         default: f_exc_base = 5'd26;
      endcase
   endfunction

   function automatic logic [4:0] f_exc_mode(input logic [1:0] t);
      case (t)
         2'd0:    f_exc_mode = MODE_SVC;
         2'd1:    f_exc_mode = MODE_ABT;
         2'd2:    f_exc_mode = MODE_IRQ;
         default: f_exc_mode = MODE_UND;
      endcase
   endfunction

   state_t      r_state;
   logic [31:0] r_shadow;
   logic [1:0]  r_exc_type;
   logic [31:0] r_ret_addr;
   logic [31:0] r_cap_cpsr;

   logic        w_we;
   logic [4:0]  w_widx;
   logic [31:0] w_wdata;
   logic        w_ld_rdy;
   logic        w_alu_rdy;
   logic        w_busy;
   logic [4:0]  w_tbase;

   assign mode       = r_shadow[4:0];
   assign bank_ridx1 = f_rmap(rd1_lidx, mode);
   assign bank_ridx2 = f_rmap(rd2_lidx, mode);
   assign w_tbase    = f_exc_base(r_exc_type);

   always_comb begin
      w_we      = 1'b0;
      w_widx    = '0;
      w_wdata   = '0;
      w_ld_rdy  = 1'b0;
      w_alu_rdy = 1'b0;
      w_busy    = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_we    = 1'b1;
            w_widx  = IDX_CPSR;
            w_wdata = RESET_CPSR;
         end
         ST_IDLE, ST_DONE: begin
            w_ld_rdy  = !(r_state == ST_IDLE && exc_req);
            w_alu_rdy = w_ld_rdy && !ld_wvalid;
            if (r_state == ST_IDLE && exc_req) begin
               w_busy = 1'b1;
            end else if (ld_wvalid) begin
               w_we    = f_wkeep(ld_widx, mode);
               w_widx  = f_rmap(ld_widx, mode);
               w_wdata = ld_wdata;
            end else if (alu_wvalid) begin
               w_we    = f_wkeep(alu_widx, mode);
               w_widx  = f_rmap(alu_widx, mode);
               w_wdata = alu_wdata;
            end
         end
         ST_SPSR: begin
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_widx  = w_tbase + 5'd2;
            w_wdata = r_cap_cpsr;
         end
         ST_LR: begin
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_widx  = w_tbase + 5'd1;
            w_wdata = r_ret_addr;
         end
         ST_CPSR: begin
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_widx  = IDX_CPSR;
            w_wdata = {r_cap_cpsr[31:8], 1'b1, r_cap_cpsr[6], 1'b0, f_exc_mode(r_exc_type)};
         end
         default: ;
      endcase
   end

   // Outputs are gated by reset so they drop asynchronously, not at the next edge.
   assign bank_we    = reset && w_we;
   assign bank_widx  = bank_we ? w_widx  : '0;
   assign bank_wdata = bank_we ? w_wdata : '0;
   assign ld_wready  = reset && w_ld_rdy;
   assign alu_wready = reset && w_alu_rdy;
   assign exc_busy   = reset && w_busy;
   assign exc_done   = reset && (r_state == ST_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_INIT;
         r_shadow   <= RESET_CPSR;
         r_exc_type <= '0;
         r_ret_addr <= '0;
         r_cap_cpsr <= '0;
      end else begin
         if (bank_we && bank_widx == IDX_CPSR)
            r_shadow <= bank_wdata;
         case (r_state)
            ST_INIT: r_state <= ST_IDLE;
            ST_IDLE: begin
               if (exc_req) begin
                  r_exc_type <= exc_type;
                  r_ret_addr <= exc_ret_addr;
                  r_cap_cpsr <= r_shadow;
                  r_state    <= ST_SPSR;
               end
            end
            ST_SPSR: r_state <= ST_LR;
            ST_LR:   r_state <= ST_CPSR;
            ST_CPSR: r_state <= ST_DONE;
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Scoreboard bench for regbank_ctrl: expected bank writes are queued by the
// stimulus and popped by a negedge monitor whenever bank_we is high.
module tb_regbank_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rd1_lidx, rd2_lidx, bank_ridx1, bank_ridx2;
   logic        alu_wvalid, alu_wready, ld_wvalid, ld_wready;
   logic [4:0]  alu_widx, ld_widx;
   logic [31:0] alu_wdata, ld_wdata;
   logic        exc_req, exc_busy, exc_done;
   logic [1:0]  exc_type;
   logic [31:0] exc_ret_addr;
   logic        bank_we;
   logic [4:0]  bank_widx, mode;
   logic [31:0] bank_wdata;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [36:0] exp_q[$];

   regbank_ctrl #(.RESET_CPSR(32'h0000_00D3)) dut (
      .clk(clk), .reset(reset),
      .rd1_lidx(rd1_lidx), .rd2_lidx(rd2_lidx),
      .bank_ridx1(bank_ridx1), .bank_ridx2(bank_ridx2),
      .alu_wvalid(alu_wvalid), .alu_widx(alu_widx), .alu_wdata(alu_wdata), .alu_wready(alu_wready),
      .ld_wvalid(ld_wvalid), .ld_widx(ld_widx), .ld_wdata(ld_wdata), .ld_wready(ld_wready),
      .exc_req(exc_req), .exc_type(exc_type), .exc_ret_addr(exc_ret_addr),
      .exc_busy(exc_busy), .exc_done(exc_done),
      .bank_we(bank_we), .bank_widx(bank_widx), .bank_wdata(bank_wdata), .mode(mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] idx, input logic [31:0] data);
      exp_q.push_back({idx, data});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: every write the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      logic [36:0] e;
      if (bank_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got idx %0d data %h expected no write", bank_widx, bank_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("write_idx", {27'd0, bank_widx}, {27'd0, e[36:32]});
            chk("write_data", bank_wdata, e[31:0]);
         end
      end else begin
         chk("idle_widx_zero", {27'd0, bank_widx}, 32'd0);
         chk("idle_wdata_zero", bank_wdata, 32'd0);
      end
   end

   initial begin
      reset = 1'b0;
      rd1_lidx = '0; rd2_lidx = '0;
      alu_wvalid = 1'b0; alu_widx = '0; alu_wdata = '0;
      ld_wvalid = 1'b0; ld_widx = '0; ld_wdata = '0;
      exc_req = 1'b0; exc_type = '0; exc_ret_addr = '0;

      repeat (2) tick();
      sample();
      chk("rst_we", {31'd0, bank_we}, 32'd0);
      chk("rst_busy", {31'd0, exc_busy}, 32'd0);
      chk("rst_done", {31'd0, exc_done}, 32'd0);
      chk("rst_ld_rdy", {31'd0, ld_wready}, 32'd0);
      chk("rst_alu_rdy", {31'd0, alu_wready}, 32'd0);
      chk("rst_mode", {27'd0, mode}, 32'h13);

      // INIT write on the first edge after release
      tick();
      reset = 1'b1;
      push(5'd16, 32'h0000_00D3);
      sample();
      chk("init_ld_rdy", {31'd0, ld_wready}, 32'd0);
      chk("init_busy", {31'd0, exc_busy}, 32'd0);
      tick();

      // SVC: banked r14 and mode-dependent reads
      rd1_lidx = 5'd17; rd2_lidx = 5'd13;
      alu_wvalid = 1'b1; alu_widx = 5'd14; alu_wdata = 32'hAAAA_0001;
      push(5'd18, 32'hAAAA_0001);
      sample();
      chk("svc_mode", {27'd0, mode}, 32'h13);
      chk("svc_rd_spsr", {27'd0, bank_ridx1}, 32'd19);
      chk("svc_rd_r13", {27'd0, bank_ridx2}, 32'd17);
      chk("svc_alu_rdy", {31'd0, alu_wready}, 32'd1);
      tick();

      alu_widx = 5'd16; alu_wdata = 32'h0000_0010;
      push(5'd16, 32'h0000_0010);
      sample();
      tick();

      // USR now in effect
      alu_widx = 5'd14; alu_wdata = 32'h0000_0005;
      push(5'd14, 32'h0000_0005);
      sample();
      chk("usr_mode", {27'd0, mode}, 32'h10);
      chk("usr_rd_spsr", {27'd0, bank_ridx1}, 32'd16);
      chk("usr_rd_r13", {27'd0, bank_ridx2}, 32'd13);
      tick();

      // ld beats alu in the same cycle
      ld_wvalid = 1'b1; ld_widx = 5'd3; ld_wdata = 32'h0000_0033;
      alu_widx = 5'd4; alu_wdata = 32'h0000_0044;
      push(5'd3, 32'h0000_0033);
      sample();
      chk("arb_alu_rdy", {31'd0, alu_wready}, 32'd0);
      chk("arb_ld_rdy", {31'd0, ld_wready}, 32'd1);
      tick();
      ld_wvalid = 1'b0;
      push(5'd4, 32'h0000_0044);
      sample();
      chk("arb_alu_rdy2", {31'd0, alu_wready}, 32'd1);
      tick();

      // discarded writes: SPSR in USR, out-of-range index
      alu_widx = 5'd17; alu_wdata = 32'hDEAD_BEEF;
      sample();
      chk("usr_spsr_we", {31'd0, bank_we}, 32'd0);
      chk("usr_spsr_rdy", {31'd0, alu_wready}, 32'd1);
      tick();
      alu_widx = 5'd20;
      sample();
      chk("idx20_we", {31'd0, bank_we}, 32'd0);
      tick();
      alu_wvalid = 1'b0;

      // IRQ entry from USR; ld held pending through the sequence
      exc_req = 1'b1; exc_type = 2'd2; exc_ret_addr = 32'h0000_1004;
      ld_wvalid = 1'b1; ld_widx = 5'd13; ld_wdata = 32'h0000_0077;
      push(5'd25, 32'h0000_0010);
      push(5'd24, 32'h0000_1004);
      push(5'd16, 32'h0000_0092);
      sample();
      chk("acc_we", {31'd0, bank_we}, 32'd0);
      chk("acc_busy", {31'd0, exc_busy}, 32'd1);
      chk("acc_ld_rdy", {31'd0, ld_wready}, 32'd0);
      chk("acc_alu_rdy", {31'd0, alu_wready}, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("seq_busy", {31'd0, exc_busy}, 32'd1);
         chk("seq_ld_rdy", {31'd0, ld_wready}, 32'd0);
         chk("seq_done", {31'd0, exc_done}, 32'd0);
         tick();
      end
      exc_req = 1'b0;
      push(5'd23, 32'h0000_0077);
      sample();
      chk("irq_done", {31'd0, exc_done}, 32'd1);
      chk("irq_mode", {27'd0, mode}, 32'h12);
      chk("irq_busy", {31'd0, exc_busy}, 32'd0);
      chk("done_ld_rdy", {31'd0, ld_wready}, 32'd1);
      tick();
      ld_wvalid = 1'b0;
      rd1_lidx = 5'd17; rd2_lidx = 5'd14;
      sample();
      chk("irq_rd_spsr", {27'd0, bank_ridx1}, 32'd25);
      chk("irq_rd_r14", {27'd0, bank_ridx2}, 32'd24);
      chk("done_pulse_end", {31'd0, exc_done}, 32'd0);
      tick();

      // ABT entry with exc_req held past DONE
      exc_req = 1'b1; exc_type = 2'd1; exc_ret_addr = 32'h0000_2008;
      push(5'd22, 32'h0000_0092);
      push(5'd21, 32'h0000_2008);
      push(5'd16, 32'h0000_0097);
      repeat (4) begin
         sample();
         tick();
      end
      exc_type = 2'd0; exc_ret_addr = 32'h0000_3000;
      sample();
      chk("abt_done", {31'd0, exc_done}, 32'd1);
      chk("abt_mode", {27'd0, mode}, 32'h17);
      tick();
      push(5'd19, 32'h0000_0097);
      sample();
      chk("reacc_busy", {31'd0, exc_busy}, 32'd1);
      tick();
      sample();
      tick();

      // now in LR: reset must abort immediately
      reset = 1'b0;
      exc_req = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, bank_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, exc_busy}, 32'd0);
      chk("mid_rst_mode", {27'd0, mode}, 32'h13);
      chk("mid_rst_ld_rdy", {31'd0, ld_wready}, 32'd0);
      repeat (2) begin
         sample();
         tick();
      end
      reset = 1'b1;
      push(5'd16, 32'h0000_00D3);
      sample();
      tick();
      repeat (3) begin
         sample();
         chk("post_rst_busy", {31'd0, exc_busy}, 32'd0);
         tick();
      end
      sample();
      chk("post_rst_mode", {27'd0, mode}, 32'h13);
      #1;
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
